// File: rtl/rgb_stream_pkg.sv
// Shared types and constants for the RGB raster streamer.
package rgb_stream_pkg;

    localparam int PIXEL_W      = 24;
    // Pixels that may be buffered or in flight at once. This matches the output FIFO depth.
    localparam int CREDIT_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic pixel_t make_pixel(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        pixel_t p;
        p.r = r;
        p.g = g;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/p2p_skid_fifo2.sv
// Two-entry FIFO that holds returned read data until the consumer accepts it.
module p2p_skid_fifo2 #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // Compute the next pointer and occupancy values from the push and pop qualifiers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ~wr_ptr_q;
        if (do_pop)  rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Update the storage, pointers and count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the storage is only two words, so it is reset. The head then reads 0 out of reset without extra muxing.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign occ_o  = count_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/rgb_stream_tx.sv
// Raster pixel streamer. It reads a W x H frame from a synchronous-read memory and
// sends it over a busy/vld/data channel, using credit-limited reads into a 2-entry buffer.
module rgb_stream_tx
    import rgb_stream_pkg::*;
#(
    parameter int DATA_W = PIXEL_W,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [DIM_W-1:0]  i_width,
    input  logic [DIM_W-1:0]  i_height,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_rgb_vld,
    output logic [DATA_W-1:0] o_rgb_data,
    input  logic              i_rgb_busy,
    output logic              o_active,
    output logic              o_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic              rd_pend_q;

    logic              mem_rd;
    logic              pop;
    logic              credit_ok;
    logic              last_col, last_row;
    logic [1:0]        occ;

    assign pop       = o_rgb_vld && !i_rgb_busy;
    assign last_col  = (col_q == width_q - DIM_W'(1));
    assign last_row  = (row_q == height_q - DIM_W'(1));
    // Buffered pixels plus the read in flight, minus this cycle's pop, must stay below the credit depth.
    assign credit_ok = ({1'b0, occ} + {2'b00, rd_pend_q}) < (3'(CREDIT_DEPTH) + {2'b00, pop});

    // Next-state logic for the FSM, the counters and the read strobe.
    always_comb begin
        // NOTE: every signal gets its default first, so no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        base_d   = base_q;
        idx_d    = idx_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        mem_rd   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    base_d   = i_base;
                    width_d  = i_width;
                    height_d = i_height;
                    idx_d    = '0;
                    col_d    = '0;
                    row_d    = '0;
                    state_d  = ((i_width != '0) && (i_height != '0)) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                mem_rd = credit_ok;
                if (credit_ok) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                        if (last_row) state_d = ST_DRAIN;
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the final pixel transfers, so DONE follows it by exactly one cycle.
                if (!rd_pend_q && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, frame-parameter, counter and in-flight registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples values from before this edge.
            state_q   <= state_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rd_pend_q <= mem_rd;
        end
    end

    p2p_skid_fifo2 #(
        .WIDTH(DATA_W)
    ) u_fifo (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .push_i     (rd_pend_q),
        .push_data_i(i_mem_data),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_o     (o_rgb_data)
    );

    assign o_rgb_vld  = (occ != 2'd0);
    assign o_mem_rd   = mem_rd;
    assign o_mem_addr = mem_rd ? (base_q + idx_q) : '0;
    assign o_active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_rgb_stream_tx.sv
// Scoreboard bench for rgb_stream_tx. The memory returns {8'h00, address}.
module tb_rgb_stream_tx;
    import rgb_stream_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_base = '0;
    logic [11:0] i_width = '0;
    logic [11:0] i_height = '0;
    logic        o_mem_rd;
    logic [15:0] o_mem_addr;
    logic [23:0] i_mem_data = '0;
    logic        o_rgb_vld;
    logic [23:0] o_rgb_data;
    logic        i_rgb_busy = 1'b0;
    logic        o_active;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_addr_q [$];
    logic [23:0] exp_pix_q [$];

    int rd_cnt, xf_cnt, vld_cnt, act_cnt, done_cnt;
    int first_rd, last_rd, first_vld, last_xf, first_act, done_cyc;
    int hold_lo = 1, hold_hi = 0;
    logic [23:0] hold_val = '0;
    bit prev_stall = 1'b0;
    logic [23:0] prev_data = '0;

    rgb_stream_tx #(.DATA_W(24), .ADDR_W(16), .DIM_W(12)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_base    (i_base),
        .i_width   (i_width),
        .i_height  (i_height),
        .o_mem_rd  (o_mem_rd),
        .o_mem_addr(o_mem_addr),
        .i_mem_data(i_mem_data),
        .o_rgb_vld (o_rgb_vld),
        .o_rgb_data(o_rgb_data),
        .i_rgb_busy(i_rgb_busy),
        .o_active  (o_active),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Synchronous-read memory model: the word equals its address.
    always @(posedge i_clk) if (o_mem_rd) i_mem_data <= {8'h00, o_mem_addr};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; xf_cnt = 0; vld_cnt = 0; act_cnt = 0; done_cnt = 0;
        first_rd = -1; last_rd = -1; first_vld = -1; last_xf = -1; first_act = -1; done_cyc = -1;
        hold_lo = 1; hold_hi = 0;
    endtask

    task automatic expect_frame(input logic [15:0] base, input int w, input int h);
        logic [15:0] a;
        for (int i = 0; i < w * h; i++) begin
            a = base + 16'(i);
            exp_addr_q.push_back(a);
            exp_pix_q.push_back({8'h00, a});
        end
    endtask

    // Call this right after next_cycle(). Returns the index k of the edge that samples start.
    task automatic start_frame(input logic [15:0] base, input logic [11:0] w, input logic [11:0] h,
                               output int k);
        i_base = base; i_width = w; i_height = h; i_start = 1'b1;
        k = cyc + 1;
        next_cycle();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int got = 0;
        for (int i = 0; i < bound && got == 0; i++) begin
            next_cycle();
            if (done_cnt > 0) got = 1;
        end
        check({name, " done_seen"}, got, 1);
        next_cycle();
        next_cycle();
        check({name, " pix_left"}, exp_pix_q.size(), 0);
        check({name, " addr_left"}, exp_addr_q.size(), 0);
    endtask

    // Monitor: compares each read and transfer against the queues and tracks event cycles.
    always @(negedge i_clk) begin
        int cur;
        logic [23:0] ep;
        logic [15:0] ea;
        cur = cyc + 1;
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (o_mem_rd) begin
                if (first_rd < 0) first_rd = cur;
                last_rd = cur;
                check("credit", ((rd_cnt + 1 - (xf_cnt + ((o_rgb_vld && !i_rgb_busy) ? 1 : 0))) <= 2) ? 1 : 0, 1);
                rd_cnt++;
                ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 16'hxxxx;
                check("rd_addr", o_mem_addr, ea);
            end
            if (o_rgb_vld) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cur;
            end
            if (prev_stall) check("hold", {o_rgb_vld, o_rgb_data}, {1'b1, prev_data});
            if (cur >= hold_lo && cur <= hold_hi) check("hold_val", {o_rgb_vld, o_rgb_data}, {1'b1, hold_val});
            if (o_rgb_vld && !i_rgb_busy) begin
                xf_cnt++;
                last_xf = cur;
                ep = (exp_pix_q.size() > 0) ? exp_pix_q.pop_front() : 24'hxxxxxx;
                check("pixel", o_rgb_data, ep);
            end
            prev_stall = o_rgb_vld && i_rgb_busy;
            prev_data  = o_rgb_data;
            if (o_active) begin
                act_cnt++;
                if (first_act < 0) first_act = cur;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cur;
            end
        end
    end

    initial begin
        int k;
        clear_stats();
        repeat (3) next_cycle();
        check("rst_outputs", {o_mem_rd, o_mem_addr, o_rgb_vld, o_rgb_data, o_active, o_done}, 0);
        i_rst = 1'b0;
        next_cycle();

        // 4x2 frame at base 0x0010 with no backpressure.
        clear_stats();
        expect_frame(16'h0010, 4, 2);
        start_frame(16'h0010, 12'd4, 12'd2, k);
        wait_done(40, "t1");
        check("t1 first_rd", first_rd, k + 1);
        check("t1 first_act", first_act, k + 1);
        check("t1 last_rd", last_rd, k + 8);
        check("t1 rd_cnt", rd_cnt, 8);
        check("t1 first_vld", first_vld, k + 3);
        check("t1 last_xf", last_xf, k + 10);
        check("t1 xf_cnt", xf_cnt, 8);
        check("t1 done_cyc", done_cyc, k + 11);
        check("t1 done_cnt", done_cnt, 1);

        // The same frame with busy asserted for cycles k+4..k+7.
        clear_stats();
        expect_frame(16'h0010, 4, 2);
        start_frame(16'h0010, 12'd4, 12'd2, k);
        hold_lo = k + 4; hold_hi = k + 7; hold_val = 24'h000011;
        for (int c = k + 1; c <= k + 8; c++) begin
            i_rgb_busy = (c >= k + 4) && (c <= k + 7);
            next_cycle();
        end
        i_rgb_busy = 1'b0;
        wait_done(40, "t2");
        check("t2 xf_cnt", xf_cnt, 8);
        check("t2 done_cnt", done_cnt, 1);

        // Address wrap-around: base 0xFFFE, 1x4 frame.
        clear_stats();
        expect_frame(16'hFFFE, 1, 4);
        start_frame(16'hFFFE, 12'd1, 12'd4, k);
        wait_done(40, "t3");
        check("t3 xf_cnt", xf_cnt, 4);
        check("t3 done_cyc", done_cyc, k + 7);

        // Zero width, then zero height.
        for (int z = 0; z < 2; z++) begin
            clear_stats();
            start_frame(16'h0100, (z == 0) ? 12'd0 : 12'd5, (z == 0) ? 12'd3 : 12'd0, k);
            repeat (4) next_cycle();
            check("t4 done_cyc", done_cyc, k + 1);
            check("t4 done_cnt", done_cnt, 1);
            check("t4 rd_cnt", rd_cnt, 0);
            check("t4 vld_cnt", vld_cnt, 0);
            check("t4 act_cnt", act_cnt, 0);
        end

        // A second start in the middle of a frame must be ignored.
        clear_stats();
        expect_frame(16'h0100, 3, 2);
        start_frame(16'h0100, 12'd3, 12'd2, k);
        next_cycle();
        start_frame(16'h0200, 12'd1, 12'd1, k);
        wait_done(40, "t5");
        repeat (4) next_cycle();
        check("t5 xf_cnt", xf_cnt, 6);
        check("t5 rd_cnt", rd_cnt, 6);
        check("t5 done_cnt", done_cnt, 1);

        // Reset after 3 transfers, then run a fresh 2x2 frame.
        clear_stats();
        expect_frame(16'h0020, 4, 2);
        start_frame(16'h0020, 12'd4, 12'd2, k);
        begin
            int n = 0;
            while (xf_cnt < 3 && n < 40) begin
                next_cycle();
                n++;
            end
            check("t6 reach3", (xf_cnt == 3) ? 1 : 0, 1);
        end
        i_rst = 1'b1;
        #1;
        check("t6 rst_outputs", {o_mem_rd, o_mem_addr, o_rgb_vld, o_rgb_data, o_active, o_done}, 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        next_cycle();
        next_cycle();
        i_rst = 1'b0;
        next_cycle();
        clear_stats();
        repeat (3) next_cycle();
        check("t6 idle_after_rst", {rd_cnt[3:0], act_cnt[3:0], vld_cnt[3:0]}, 0);
        expect_frame(16'h0040, 2, 2);
        start_frame(16'h0040, 12'd2, 12'd2, k);
        wait_done(40, "t6");
        check("t6 xf_cnt", xf_cnt, 4);
        check("t6 done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_stream_tx.md
# rgb_stream_tx

Raster pixel streamer that reads a frame of 24-bit RGB pixels from a synchronous-read pixel memory and transmits it over the point-to-point busy/vld/data handshake consumed by the colour-transform stage on its `i_rgb_*` port. It is the transmitting end of that input channel. It feeds the transform from the testbench or SoC side, honours consumer backpressure, and signals frame completion. A 2-entry output buffer with read-credit accounting sustains one pixel per cycle when the consumer is not busy.

## Interface
Parameters:
- `DATA_W`, 24: pixel width in bits, packed {R[23:16], G[15:8], B[7:0]}; passed through unmodified.
- `ADDR_W`, 16: pixel memory address width.
- `DIM_W`, 12: width of the frame-dimension inputs.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  single-cycle frame start; accepted only in IDLE.
- `i_base`  in  ADDR_W  address of the first pixel; latched on an accepted start.
- `i_width`  in  DIM_W  pixels per row; latched on an accepted start.
- `i_height`  in  DIM_W  rows per frame; latched on an accepted start.
- `o_mem_rd`  out  1  memory read strobe.
- `o_mem_addr`  out  ADDR_W  read address; valid while `o_mem_rd`=1.
- `i_mem_data`  in  DATA_W  read data; valid exactly 1 cycle after `o_mem_rd`.
- `o_rgb_vld`  out  1  output pixel valid.
- `o_rgb_data`  out  DATA_W  output pixel.
- `i_rgb_busy`  in  1  consumer busy (backpressure).
- `o_active`  out  1  high in RUN and DRAIN.
- `o_done`  out  1  one-cycle pulse after the last pixel transfers.

## Operation
- Transfer rule: a pixel transfers on a rising edge where `o_rgb_vld`=1 and `i_rgb_busy`=0. While `o_rgb_vld`=1 and `i_rgb_busy`=1, `o_rgb_data` holds stable. `o_rgb_vld` never drops without a transfer.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN when `i_start`=1 and both `i_width` and `i_height` are non-zero.
  - IDLE→DONE when `i_start`=1 and either dimension is 0; no reads or transfers occur.
  - RUN→DRAIN in the cycle the final read issues.
  - DRAIN→DONE when the buffer is empty and no read is in flight.
  - DONE→IDLE unconditionally.
  - `i_start` is ignored outside IDLE.
- Counters:
  - `col` counts 0..width-1; at width-1 it wraps to 0 and `row` increments.
  - The final read issues at `row`=height-1 and `col`=width-1.
  - `o_mem_addr` = latched base + linear read index, modulo 2^ADDR_W. Wrap-around is legal and silent.
- Credit rule: in RUN, `o_mem_rd`=1 iff (buffer occupancy + reads in flight − transfer this cycle) < 2. The buffer can therefore never overflow.
- Buffer: 2-entry FIFO. Returned data is written at the end of the cycle after `o_mem_rd`. `o_rgb_vld` = buffer not empty. `o_rgb_data` = head entry.
- Transfer order equals address order: row-major, no reordering.
- `o_done` is high only in DONE. `o_active` is high in RUN and DRAIN.

## Timing
- Reset values: all outputs 0 (`o_mem_rd`, `o_mem_addr`, `o_rgb_vld`, `o_rgb_data`, `o_active`, `o_done`). FSM in IDLE, buffer empty, counters 0.
- Start sampled at edge k:
  - `o_active`=1 and first `o_mem_rd` in cycle k+1.
  - First `o_rgb_vld` in cycle k+3.
- Throughput: with `i_rgb_busy` held at 0, one transfer per cycle with no bubbles. A W×H frame completes its last transfer in cycle k+2+W·H. `o_done` follows in the next cycle.
- Busy asserted for N cycles: reads stall once occupancy plus in-flight reaches 2. Streaming resumes at 1 pixel/cycle from the first non-busy cycle, with no lost or duplicated pixels.
- Zero-dimension start at edge k: `o_done`=1 in cycle k+1 and `o_active` stays 0.
- Reset asserted mid-frame: all outputs go to 0 asynchronously and any in-flight read data is discarded. After deassertion the block is in IDLE and needs a new `i_start`.

## Structure
- Shared package `rgb_stream_pkg` holds:
  - the FSM state enum (IDLE/RUN/DRAIN/DONE);
  - the pixel typedef (`DATA_W`-bit packed RGB);
  - the credit depth constant (2).
- The 2-entry FIFO is a natural sub-module, `p2p_skid_fifo2`, parameterised by width, with push, pop, occupancy, and head outputs. The FSM, counters and credit logic stay in the top module.

## Test plan
- 4×2 frame, base 0x0010, memory word = address, busy=0:
  - reads 0x0010..0x0017 in consecutive cycles;
  - 8 transfers with data 0x000010..0x000017 in cycles k+3..k+10;
  - `o_done` pulse at k+11.
- Same frame with busy=1 for cycles k+4..k+7:
  - `o_rgb_data` holds 0x000011 throughout;
  - at most 2 reads outstanding;
  - final sequence is identical and complete.
- Base 0xFFFE, 1×4 frame: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
- `i_width`=0 or `i_height`=0: `o_done` at k+1, no `o_mem_rd`, no `o_rgb_vld`.
- `i_start` pulsed again mid-frame: ignored; frame count and pixel count unchanged.
- `i_rst` asserted after 3 transfers: all outputs 0 immediately. A new 2×2 start then transfers exactly 4 pixels.
